// File: rtl/pulse_guard_pkg.sv
// Shared definitions for the multi-channel laser pulse guard:
// per-channel FSM states, fail-bit positions and the default counter width.
package pulse_guard_pkg;

    localparam int DEFAULT_CNT_W = 32;

    // Positions of the three latched faults inside a channel's fail vector.
    localparam int NUM_FAIL   = 3;
    localparam int FAIL_LOWER = 0;
    localparam int FAIL_UPPER = 1;
    localparam int FAIL_RATE  = 2;

    typedef enum logic [2:0] {
        DISARMED   = 3'd0,
        WAIT_LOW   = 3'd1,
        WAIT_FIRST = 3'd2,
        HIGH       = 3'd3,
        LOW        = 3'd4
    } pg_state_e;

endpackage

// File: rtl/pulse_channel_check.sv
// One laser channel: arming FSM, saturating width/period counters and the
// three fault latches (too short, too long, rate too high).
// Optional macro PULSE_GUARD_FAULT_COUNT_EN adds an 8-bit saturating fault
// event counter on fault_count_o.
module pulse_channel_check
    import pulse_guard_pkg::*;
#(
    parameter int CNT_W               = DEFAULT_CNT_W,
    parameter int LIMIT_ZERO_DISABLES = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ready_i,
    input  logic                pulse_i,
    input  logic [CNT_W-1:0]    lower_i,
    input  logic [CNT_W-1:0]    upper_i,
    input  logic [CNT_W-1:0]    rate_i,
    input  logic                clear_i,
    output logic [NUM_FAIL-1:0] fail_o
`ifdef PULSE_GUARD_FAULT_COUNT_EN
    ,
    output logic [7:0]          fault_count_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    pg_state_e            state_q, state_d;
    logic [CNT_W-1:0]     width_q, width_d;
    logic [CNT_W-1:0]     period_q, period_d;
    // Set once the too-long fault fired for the current pulse so it is
    // reported as a single event rather than every remaining high cycle.
    logic                 upper_seen_q, upper_seen_d;
    logic [NUM_FAIL-1:0]  fail_q, fail_d;
    logic [NUM_FAIL-1:0]  det;
    logic                 lower_en, upper_en, rate_en;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // A zero limit switches its check off when LIMIT_ZERO_DISABLES is set.
    assign lower_en = (LIMIT_ZERO_DISABLES == 0) || (lower_i != '0);
    assign upper_en = (LIMIT_ZERO_DISABLES == 0) || (upper_i != '0);
    assign rate_en  = (LIMIT_ZERO_DISABLES == 0) || (rate_i  != '0);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= DISARMED;
        else         state_q <= state_d;
    end

    // Next-state logic; dropping laser_ready disarms from any state.
    always_comb begin
        state_d = state_q;
        if (!ready_i) begin
            state_d = DISARMED;
        end else begin
            case (state_q)
                DISARMED:   state_d = pulse_i ? WAIT_LOW : WAIT_FIRST;
                WAIT_LOW:   if (!pulse_i) state_d = WAIT_FIRST;
                WAIT_FIRST: if (pulse_i)  state_d = HIGH;
                HIGH:       if (!pulse_i) state_d = LOW;
                LOW:        if (pulse_i)  state_d = HIGH;
                default:    state_d = DISARMED;
            endcase
        end
    end

    // Output logic: counter updates and fault detection for this sample.
    always_comb begin
        width_d      = width_q;
        period_d     = period_q;
        upper_seen_d = upper_seen_q;
        det          = '0;
        if (!ready_i) begin
            width_d      = '0;
            period_d     = '0;
            upper_seen_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_FIRST: begin
                    if (pulse_i) begin
                        width_d      = CNT_ONE;
                        period_d     = CNT_ONE;
                        upper_seen_d = 1'b0;
                    end
                end
                HIGH: begin
                    period_d = sat_inc(period_q);
                    if (pulse_i) begin
                        width_d = sat_inc(width_q);
                        // This sample is high cycle width_q+1; fail once it exceeds upper.
                        if (upper_en && !upper_seen_q && (width_q >= upper_i)) begin
                            det[FAIL_UPPER] = 1'b1;
                            upper_seen_d    = 1'b1;
                        end
                    end else if (lower_en && (width_q < lower_i)) begin
                        det[FAIL_LOWER] = 1'b1;
                    end
                end
                LOW: begin
                    if (pulse_i) begin
                        // A saturated period is never below any limit, so it passes.
                        if (rate_en && (period_q < rate_i)) det[FAIL_RATE] = 1'b1;
                        width_d      = CNT_ONE;
                        period_d     = CNT_ONE;
                        upper_seen_d = 1'b0;
                    end else begin
                        period_d = sat_inc(period_q);
                    end
                end
                default: ;
            endcase
        end
    end

    // New detections win over a simultaneous clear.
    always_comb begin
        fail_d = det | (fail_q & {NUM_FAIL{~clear_i}});
    end

    // Counters and fault latches.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            width_q      <= '0;
            period_q     <= '0;
            upper_seen_q <= 1'b0;
            fail_q       <= '0;
        end else begin
            width_q      <= width_d;
            period_q     <= period_d;
            upper_seen_q <= upper_seen_d;
            fail_q       <= fail_d;
        end
    end

    assign fail_o = fail_q;

`ifdef PULSE_GUARD_FAULT_COUNT_EN
    logic [7:0] fault_cnt_q, fault_cnt_d;

    // One count per cycle with any detection, cleared with the latches, saturating.
    always_comb begin
        fault_cnt_d = fault_cnt_q;
        if (clear_i) fault_cnt_d = '0;
        if ((|det) && (fault_cnt_d != 8'hFF)) fault_cnt_d = fault_cnt_d + 8'd1;
    end

    // Fault event counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) fault_cnt_q <= '0;
        else         fault_cnt_q <= fault_cnt_d;
    end

    assign fault_count_o = fault_cnt_q;
`endif

endmodule

// File: rtl/multi_channel_pulse_guard.sv
// NUM_CH-channel laser pulse guard: one pulse_channel_check per channel, a
// registered TA shutdown from all latched faults and a packed status byte.
// Optional macro PULSE_GUARD_FAULT_COUNT_EN adds the fault_count output.
module multi_channel_pulse_guard
    import pulse_guard_pkg::*;
#(
    parameter int NUM_CH              = 4,
    parameter int CNT_W               = DEFAULT_CNT_W,
    parameter int LIMIT_ZERO_DISABLES = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    laser_ready,
    input  logic [NUM_CH-1:0]       laser_pulse,
    input  logic [NUM_CH*CNT_W-1:0] pulse_width_lower_limit,
    input  logic [NUM_CH*CNT_W-1:0] pulse_width_upper_limit,
    input  logic [NUM_CH*CNT_W-1:0] rate_lower_limit,
    input  logic [NUM_CH-1:0]       clear_fail,
    output logic [NUM_CH-1:0]       pulse_lower_limit_fail,
    output logic [NUM_CH-1:0]       pulse_upper_limit_fail,
    output logic [NUM_CH-1:0]       rate_lower_limit_fail,
    output logic                    TA_shutdown,
    output logic [7:0]              status
`ifdef PULSE_GUARD_FAULT_COUNT_EN
    ,
    output logic [NUM_CH*8-1:0]     fault_count
`endif
);

    logic [NUM_CH-1:0] ch_any_fail;
    logic              ta_q, ta_d;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [NUM_FAIL-1:0] ch_fail;

        pulse_channel_check #(
            .CNT_W              (CNT_W),
            .LIMIT_ZERO_DISABLES(LIMIT_ZERO_DISABLES)
        ) u_check (
            .clk_i   (clk),
            .rst_ni  (rstn),
            .ready_i (laser_ready),
            .pulse_i (laser_pulse[n]),
            .lower_i (pulse_width_lower_limit[n*CNT_W +: CNT_W]),
            .upper_i (pulse_width_upper_limit[n*CNT_W +: CNT_W]),
            .rate_i  (rate_lower_limit[n*CNT_W +: CNT_W]),
            .clear_i (clear_fail[n]),
            .fail_o  (ch_fail)
`ifdef PULSE_GUARD_FAULT_COUNT_EN
            ,
            .fault_count_o(fault_count[n*8 +: 8])
`endif
        );

        assign pulse_lower_limit_fail[n] = ch_fail[FAIL_LOWER];
        assign pulse_upper_limit_fail[n] = ch_fail[FAIL_UPPER];
        assign rate_lower_limit_fail[n]  = ch_fail[FAIL_RATE];
        assign ch_any_fail[n]            = |ch_fail;
    end

    // Status byte: channel n's any-fail at bit n, unused upper bits zero.
    for (genvar b = 0; b < 8; b++) begin : g_status
        if (b < NUM_CH) begin : g_used
            assign status[b] = ch_any_fail[b];
        end else begin : g_pad
            assign status[b] = 1'b0;
        end
    end

    // Shutdown request is the OR of every latched fault.
    always_comb begin
        ta_d = |ch_any_fail;
    end

    // Registered shutdown; lags the fail latches by one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ta_q <= 1'b0;
        else       ta_q <= ta_d;
    end

    assign TA_shutdown = ta_q;

endmodule

// File: tb/tb_multi_channel_pulse_guard.sv
// Self-checking bench for multi_channel_pulse_guard: directed scenarios plus
// a randomized phase, every cycle compared against an edge/time based model.
module tb_multi_channel_pulse_guard;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;

    logic                    clk = 1'b0;
    logic                    rstn;
    logic                    laser_ready;
    logic [NUM_CH-1:0]       laser_pulse;
    logic [NUM_CH-1:0]       clear_fail;
    logic [NUM_CH*CNT_W-1:0] lo_flat, up_flat, rt_flat;
    logic [NUM_CH-1:0]       pulse_lower_limit_fail, pulse_upper_limit_fail, rate_lower_limit_fail;
    logic                    TA_shutdown;
    logic [7:0]              status;
`ifdef PULSE_GUARD_FAULT_COUNT_EN
    logic [NUM_CH*8-1:0]     fault_count;
`endif

    logic [CNT_W-1:0] lo_lim[NUM_CH];
    logic [CNT_W-1:0] up_lim[NUM_CH];
    logic [CNT_W-1:0] rt_lim[NUM_CH];

    int checks = 0;
    int errors = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    always_comb begin
        lo_flat = '0;
        up_flat = '0;
        rt_flat = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            lo_flat[i*CNT_W +: CNT_W] = lo_lim[i];
            up_flat[i*CNT_W +: CNT_W] = up_lim[i];
            rt_flat[i*CNT_W +: CNT_W] = rt_lim[i];
        end
    end

    multi_channel_pulse_guard #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .LIMIT_ZERO_DISABLES(1)
    ) dut (
        .clk                    (clk),
        .rstn                   (rstn),
        .laser_ready            (laser_ready),
        .laser_pulse            (laser_pulse),
        .pulse_width_lower_limit(lo_flat),
        .pulse_width_upper_limit(up_flat),
        .rate_lower_limit       (rt_flat),
        .clear_fail             (clear_fail),
        .pulse_lower_limit_fail (pulse_lower_limit_fail),
        .pulse_upper_limit_fail (pulse_upper_limit_fail),
        .rate_lower_limit_fail  (rate_lower_limit_fail),
        .TA_shutdown            (TA_shutdown),
        .status                 (status)
`ifdef PULSE_GUARD_FAULT_COUNT_EN
        ,
        .fault_count            (fault_count)
`endif
    );

    // ---------------- reference model ----------------
    // A measured rising edge is a high sample directly after an armed low
    // sample. Widths and periods are differences of sample indices.
    int unsigned cyc = 0;
    bit          prev_armed_low[NUM_CH];
    bit          have_rise[NUM_CH];
    int unsigned last_rise[NUM_CH];
    bit          in_pulse[NUM_CH];
    bit          long_reported[NUM_CH];
    bit          m_lo[NUM_CH], m_up[NUM_CH], m_rt[NUM_CH];
    bit          m_ta;

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            prev_armed_low[c] = 0; have_rise[c] = 0; last_rise[c] = 0;
            in_pulse[c] = 0; long_reported[c] = 0;
            m_lo[c] = 0; m_up[c] = 0; m_rt[c] = 0;
        end
        m_ta = 0;
    endtask

    task automatic model_sample();
        bit any_before;
        bit dl, du, dr;
        if (!rstn) begin
            model_reset();
            return;
        end
        any_before = 0;
        for (int c = 0; c < NUM_CH; c++) any_before |= m_lo[c] | m_up[c] | m_rt[c];
        for (int c = 0; c < NUM_CH; c++) begin
            dl = 0; du = 0; dr = 0;
            if (!laser_ready) begin
                have_rise[c] = 0;
                in_pulse[c]  = 0;
            end else if (laser_pulse[c]) begin
                if (prev_armed_low[c]) begin
                    if (have_rise[c] && rt_lim[c] != 0 && (cyc - last_rise[c]) < rt_lim[c]) dr = 1;
                    have_rise[c] = 1; last_rise[c] = cyc; in_pulse[c] = 1; long_reported[c] = 0;
                end else if (in_pulse[c]) begin
                    if (up_lim[c] != 0 && !long_reported[c] && (cyc - last_rise[c] + 1) > up_lim[c]) begin
                        du = 1; long_reported[c] = 1;
                    end
                end
            end else if (in_pulse[c]) begin
                if (lo_lim[c] != 0 && (cyc - last_rise[c]) < lo_lim[c]) dl = 1;
                in_pulse[c] = 0;
            end
            prev_armed_low[c] = laser_ready && !laser_pulse[c];
            m_lo[c] = dl | (m_lo[c] & !clear_fail[c]);
            m_up[c] = du | (m_up[c] & !clear_fail[c]);
            m_rt[c] = dr | (m_rt[c] & !clear_fail[c]);
        end
        m_ta = any_before;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic compare_model();
        logic [NUM_CH-1:0] el, eu, er;
        logic [7:0]        es;
        es = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            el[c] = m_lo[c]; eu[c] = m_up[c]; er[c] = m_rt[c];
            es[c] = m_lo[c] | m_up[c] | m_rt[c];
        end
        check("fails", 64'({pulse_lower_limit_fail, pulse_upper_limit_fail, rate_lower_limit_fail}),
              64'({el, eu, er}));
        check("ta_shutdown", 64'(TA_shutdown), 64'(m_ta));
        check("status", 64'(status), 64'(es));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_sample();
            #1;
            compare_model();
            cyc++;
        end
    endtask

    task automatic pulse(input int ch, input int high, input int low);
        laser_pulse[ch] = 1'b1;
        step(high);
        laser_pulse[ch] = 1'b0;
        step(low);
    endtask

    task automatic base_limits();
        for (int c = 0; c < NUM_CH; c++) begin
            lo_lim[c] = 10; up_lim[c] = 100; rt_lim[c] = 0;
        end
        rt_lim[0] = 1000;
        lo_lim[2] = 0;
        lo_lim[3] = 0; up_lim[3] = 0; rt_lim[3] = 1000;
    endtask

    int unsigned left[NUM_CH];
    int unsigned rdy_off;

    initial begin
        rstn = 1'b0; laser_ready = 1'b0; laser_pulse = '0; clear_fail = '0;
        base_limits();
        model_reset();
        step(3);
        check("reset_fails", 64'({pulse_lower_limit_fail, pulse_upper_limit_fail, rate_lower_limit_fail}), 64'(0));
        check("reset_ta", 64'(TA_shutdown), 64'(0));
        rstn = 1'b1; laser_ready = 1'b1;
        step(3);

        // Channel 0: legal 50/950 pulses.
        for (int k = 0; k < 5; k++) pulse(0, 50, 950);
        check("ch0_no_fail", 64'({pulse_lower_limit_fail[0], pulse_upper_limit_fail[0], rate_lower_limit_fail[0]}), 64'(0));
        check("ch0_ta", 64'(TA_shutdown), 64'(0));

        // Channel 1: 9-cycle pulse is too short, 10 passes.
        pulse(1, 9, 1);
        check("ch1_short", 64'(pulse_lower_limit_fail), 64'(4'b0010));
        check("ch1_ta_lag", 64'(TA_shutdown), 64'(0));
        step(1);
        check("ch1_ta", 64'(TA_shutdown), 64'(1));
        clear_fail[1] = 1'b1; step(1); clear_fail[1] = 1'b0;
        check("ch1_clear", 64'(pulse_lower_limit_fail[1]), 64'(0));
        check("ch1_clear_ta_hold", 64'(TA_shutdown), 64'(1));
        step(1);
        check("ch1_clear_ta", 64'(TA_shutdown), 64'(0));
        pulse(1, 10, 1);
        check("ch1_equal_pass", 64'(pulse_lower_limit_fail[1]), 64'(0));

        // Channel 2: 100 passes, 150 fails on the 101st high cycle.
        pulse(2, 100, 5);
        check("ch2_100_pass", 64'(pulse_upper_limit_fail[2]), 64'(0));
        laser_pulse[2] = 1'b1;
        step(100);
        check("ch2_before_101", 64'(pulse_upper_limit_fail[2]), 64'(0));
        step(1);
        check("ch2_at_101", 64'(pulse_upper_limit_fail[2]), 64'(1));
        step(49); laser_pulse[2] = 1'b0; step(5);
        // Clear in the same cycle as a new violation: set dominates.
        laser_pulse[2] = 1'b1;
        step(100);
        clear_fail[2] = 1'b1; step(1); clear_fail[2] = 1'b0;
        check("ch2_set_dominates", 64'(pulse_upper_limit_fail[2]), 64'(1));
        step(49); laser_pulse[2] = 1'b0; step(3);
        clear_fail[2] = 1'b1; step(1); clear_fail[2] = 1'b0;
        check("ch2_clear", 64'(pulse_upper_limit_fail[2]), 64'(0));
        step(1);
        check("ch2_clear_ta", 64'(TA_shutdown), 64'(0));

        // Channel 3: rate limit 1000.
        pulse(3, 1, 998);
        laser_pulse[3] = 1'b1; step(1); laser_pulse[3] = 1'b0;
        check("ch3_999_fail", 64'(rate_lower_limit_fail[3]), 64'(1));
        clear_fail[3] = 1'b1; step(1); clear_fail[3] = 1'b0;
        step(998);
        laser_pulse[3] = 1'b1; step(1); laser_pulse[3] = 1'b0;
        step(2);
        check("ch3_1000_pass", 64'(rate_lower_limit_fail[3]), 64'(0));
        rt_lim[3] = 0;
        for (int k = 0; k < 5; k++) pulse(3, 1, 4);
        check("ch3_rate_zero", 64'(rate_lower_limit_fail[3]), 64'(0));

        // laser_ready rising mid-pulse: partial pulse ignored.
        laser_ready = 1'b0; step(3);
        laser_pulse[1] = 1'b1; step(2);
        laser_ready = 1'b1; step(3);
        laser_pulse[1] = 1'b0; step(2);
        check("ready_mid_pulse", 64'(pulse_lower_limit_fail[1]), 64'(0));
        pulse(1, 5, 1);
        check("ready_next_pulse", 64'(pulse_lower_limit_fail[1]), 64'(1));

        // Randomized phase.
        rdy_off = 0;
        for (int c = 0; c < NUM_CH; c++) left[c] = 0;
        for (int t = 0; t < 6000; t++) begin
            if (t % 500 == 0) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    lo_lim[c] = $urandom_range(0, 20);
                    up_lim[c] = $urandom_range(0, 40);
                    rt_lim[c] = $urandom_range(0, 60);
                end
            end
            if (rdy_off != 0) begin
                laser_ready = 1'b0; rdy_off--;
            end else begin
                laser_ready = 1'b1;
                if ($urandom_range(0, 299) == 0) rdy_off = $urandom_range(1, 5);
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (left[c] == 0) begin
                    laser_pulse[c] = ~laser_pulse[c];
                    left[c] = laser_pulse[c] ? $urandom_range(1, 30) : $urandom_range(1, 60);
                end
                left[c]--;
                clear_fail[c] = ($urandom_range(0, 59) == 0);
            end
            step(1);
        end

        // Asynchronous reset in the middle of a pulse.
        clear_fail = '0; laser_ready = 1'b1; laser_pulse = '0;
        base_limits();
        step(3);
        pulse(1, 3, 1);
        check("pre_reset_short", 64'(pulse_lower_limit_fail[1]), 64'(1));
        laser_pulse[2] = 1'b1; step(5);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_fails", 64'({pulse_lower_limit_fail, pulse_upper_limit_fail, rate_lower_limit_fail}), 64'(0));
        check("async_rst_ta", 64'(TA_shutdown), 64'(0));
        check("async_rst_status", 64'(status), 64'(0));
        step(2);
        rstn = 1'b1; laser_pulse = '0;
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_channel_pulse_guard.md
Name: multi_channel_pulse_guard

Overview:
Parametrised successor to the single-channel laser pulse limit checker. It monitors NUM_CH synchronised laser pulse inputs, each with its own run-time pulse-width lower/upper limits and minimum period. Each channel latches pulse-too-short, pulse-too-long and rate-too-high faults. The block drives a combined registered TA shutdown and a packed status word for the I2C register file.

Parameters:
- NUM_CH, 4, number of monitored laser channels (1..8)
- CNT_W, 32, width of the width/period counters and limit fields (cycles of clk)
- LIMIT_ZERO_DISABLES, 1, when 1 a limit value of 0 disables that check

Ports:
- clk, in, 1, system clock (clk_div2 domain)
- rstn, in, 1, asynchronous active-low reset
- laser_ready, in, 1, arming qualifier; checks run only while high
- laser_pulse, in, NUM_CH, pre-synchronised pulse inputs, one bit per channel
- pulse_width_lower_limit, in, NUM_CH*CNT_W, per-channel minimum high time; channel n occupies bits [n*CNT_W +: CNT_W]
- pulse_width_upper_limit, in, NUM_CH*CNT_W, per-channel maximum high time
- rate_lower_limit, in, NUM_CH*CNT_W, per-channel minimum rising-to-rising period
- clear_fail, in, NUM_CH, per-channel clear of latched faults; level-sensitive
- pulse_lower_limit_fail, out, NUM_CH, latched too-short fault
- pulse_upper_limit_fail, out, NUM_CH, latched too-long fault
- rate_lower_limit_fail, out, NUM_CH, latched rate fault
- TA_shutdown, out, 1, registered OR of all latched faults
- status, out, 8, {ch_any_fail[min(NUM_CH,8)-1:0], zero-padded}

Behaviour:
- Reset: all fail outputs, TA_shutdown and status = 0; every channel FSM goes to DISARMED; counters = 0.
- Per-channel FSM:
  - DISARMED: entered when laser_ready = 0. If laser_ready = 1 and pulse = 1, go to WAIT_LOW. If laser_ready = 1 and pulse = 0, go to WAIT_FIRST.
  - WAIT_LOW: waits for pulse = 0, then goes to WAIT_FIRST. No partial-pulse measurement.
  - WAIT_FIRST: on pulse = 1, go to HIGH with width_cnt = 1 and period_cnt = 1. The first edge has no period check.
  - HIGH: width_cnt++ each cycle the pulse stays high. On pulse = 0, do the lower check and go to LOW.
  - LOW: on pulse = 1, do the period check, go to HIGH, and reset width_cnt and period_cnt to 1.
  - period_cnt increments in both HIGH and LOW.
  - laser_ready falling in any state returns the FSM to DISARMED; latched faults are kept.
- Counters saturate at all-ones and never wrap. A saturated period_cnt passes any rate check.
- Lower check, at the falling edge: fail if width_cnt < lower. Equal passes.
- Upper check, in HIGH: fail the cycle width_cnt would exceed upper, i.e. in the (upper+1)-th high cycle. The fault does not wait for the falling edge.
- Rate check, at the rising edge in LOW: fail if period_cnt < rate_lower_limit. period_cnt counts cycles since the previous rising edge.
- Fail outputs register one cycle after the detecting sample.
- A limit of 0 disables its check (LIMIT_ZERO_DISABLES = 1).
- Limits are sampled live. A limit change mid-pulse applies from the next cycle.
- Clear: clear_fail[n] = 1 zeroes channel n's latches. If a new fault detection and clear occur in the same cycle, set dominates and the fault stays 1. Clear does not reset the FSM or counters.
- TA_shutdown = registered OR of all NUM_CH*3 latched fails, so it lags a fail output by one cycle.

Optional Feature:
- Macro: PULSE_GUARD_FAULT_COUNT_EN.
- When defined: adds output fault_count (NUM_CH*8), one 8-bit saturating counter per channel.
  - Increments once per new fault event of any type.
  - Two fault types in the same cycle count as 1.
  - Cleared by clear_fail[n] and by reset; saturates at 255.
- When undefined: the port and the logic are absent.

Decomposition:
- Package pulse_guard_pkg holds:
  - FSM state enum {DISARMED, WAIT_LOW, WAIT_FIRST, HIGH, LOW}
  - fail-bit index constants FAIL_LOWER = 0, FAIL_UPPER = 1, FAIL_RATE = 2
  - default CNT_W
- Sub-module pulse_channel_check contains one FSM, its counters and three fail latches. The top instantiates it NUM_CH times in a generate loop and builds the OR and status logic.

Test Plan:
- Channel 0, limits lower = 10, upper = 100, rate = 1000, laser_ready = 1. Pulses 50 high / 950 low, repeated 5 times -> no fails, TA_shutdown = 0.
- Channel 1, a 9-cycle pulse -> pulse_lower_limit_fail[1] = 1 one cycle after the falling-edge sample, TA_shutdown = 1 one cycle later, other channels unaffected. A 10-cycle pulse passes.
- Channel 2, a 150-cycle pulse with upper = 100 -> fail[2] rises after the 101st high cycle while the pulse is still high. A 100-cycle pulse passes.
- Channel 3, rising edges 999 cycles apart with rate = 1000 -> rate fail. Edges 1000 cycles apart pass. Rate limit = 0 -> no fail at a 5-cycle period.
- Clear asserted in the same cycle as a new upper violation -> the fail stays 1. Clear alone -> fail = 0 next cycle and TA_shutdown = 0 one cycle after that.
- laser_ready rising mid-pulse -> that pulse is ignored (no lower fail); the next full pulse is checked. rstn pulsed mid-pulse -> all outputs 0 asynchronously.
